draw_scheduler: RTL and testbench

- Per-frame sequencer that owns the single pixel-write port of the VGA framebuffer.
- On each frame tick it runs the clear-screen engine to completion. It then pulls line segments one at a time from a segment source (LineControl-style) and runs the line drawer for each.
- It multiplexes whichever engine is active onto fb_x/fb_y/fb_color/fb_write, and reports frame completion and overrun.

---
 rtl/draw_scheduler.sv | 219 +++++++++++++++++++++
 tb/tb_draw_scheduler.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_scheduler.sv
// draw_scheduler: per-frame sequencer owning the framebuffer pixel-write port.
// On frame_tick it runs the clear engine to completion. It then pulls line
// segments one at a time and runs the line drawer for each segment.
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   frame_tick                      new-frame request pulse
//   clr_start/clr_done/clr_x/clr_y  clear engine handshake and pixel address
//   seg_valid/seg_ready/seg_*       segment source handshake and payload
//   ld_start/ld_x0..ld_y1           line drawer start pulse and held endpoints
//   ld_x/ld_y/ld_pixel_valid/ld_done line drawer pixel stream and completion
//   fb_x/fb_y/fb_color/fb_write     muxed framebuffer write port
//   busy/frame_done/overrun/seg_count status
module draw_scheduler #(
    parameter int unsigned COORD_W  = 11,
    parameter int unsigned MAX_SEGS = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               frame_tick,
    output logic               clr_start,
    input  logic               clr_done,
    input  logic [COORD_W-1:0] clr_x,
    input  logic [COORD_W-1:0] clr_y,
    input  logic               seg_valid,
    output logic               seg_ready,
    input  logic [COORD_W-1:0] seg_x0,
    input  logic [COORD_W-1:0] seg_y0,
    input  logic [COORD_W-1:0] seg_x1,
    input  logic [COORD_W-1:0] seg_y1,
    input  logic               seg_last,
    output logic               ld_start,
    output logic [COORD_W-1:0] ld_x0,
    output logic [COORD_W-1:0] ld_y0,
    output logic [COORD_W-1:0] ld_x1,
    output logic [COORD_W-1:0] ld_y1,
    input  logic [COORD_W-1:0] ld_x,
    input  logic [COORD_W-1:0] ld_y,
    input  logic               ld_pixel_valid,
    input  logic               ld_done,
    output logic [COORD_W-1:0] fb_x,
    output logic [COORD_W-1:0] fb_y,
    output logic               fb_color,
    output logic               fb_write,
    output logic               busy,
    output logic               frame_done,
    output logic               overrun,
    output logic [CNT_W-1:0]   seg_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_DRAW  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [CNT_W-1:0] SEG_CAP = CNT_W'(MAX_SEGS);

    logic [2:0]         state_q, state_d;
    logic               clr_start_q, clr_start_d;
    logic               ld_start_q, ld_start_d;
    logic               frame_done_q, frame_done_d;
    logic               busy_q, busy_d;
    logic               overrun_q, overrun_d;
    logic [CNT_W-1:0]   seg_count_q, seg_count_d;
    logic               last_q, last_d;
    logic [COORD_W-1:0] ld_x0_q, ld_x0_d, ld_y0_q, ld_y0_d;
    logic [COORD_W-1:0] ld_x1_q, ld_x1_d, ld_y1_q, ld_y1_d;
    logic [COORD_W-1:0] fb_x_q, fb_x_d, fb_y_q, fb_y_d;
    logic               fb_color_q, fb_color_d;
    logic               fb_write_d;

    logic cap_hit;
    logic seg_ready_d;
    logic seg_xfer;

    // Segment budget for this frame is exhausted.
    assign cap_hit     = (seg_count_q >= SEG_CAP);
    assign seg_ready_d = (state_q == S_FETCH) && !cap_hit;
    assign seg_xfer    = seg_ready_d && seg_valid;

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            clr_start_q  <= 1'b0;
            ld_start_q   <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            seg_count_q  <= '0;
            last_q       <= 1'b0;
            ld_x0_q      <= '0;
            ld_y0_q      <= '0;
            ld_x1_q      <= '0;
            ld_y1_q      <= '0;
            fb_x_q       <= '0;
            fb_y_q       <= '0;
            fb_color_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_start_q  <= clr_start_d;
            ld_start_q   <= ld_start_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            seg_count_q  <= seg_count_d;
            last_q       <= last_d;
            ld_x0_q      <= ld_x0_d;
            ld_y0_q      <= ld_y0_d;
            ld_x1_q      <= ld_x1_d;
            ld_y1_q      <= ld_y1_d;
            fb_x_q       <= fb_x_d;
            fb_y_q       <= fb_y_d;
            fb_color_q   <= fb_color_d;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        clr_start_d = 1'b0;
        ld_start_d  = 1'b0;
        seg_count_d = seg_count_q;
        last_d      = last_q;
        ld_x0_d     = ld_x0_q;
        ld_y0_d     = ld_y0_q;
        ld_x1_d     = ld_x1_q;
        ld_y1_d     = ld_y1_q;

        case (state_q)
            S_IDLE: begin
                if (frame_tick) begin
                    state_d     = S_CLEAR;
                    clr_start_d = 1'b1;
                    seg_count_d = '0;
                end
            end
            S_CLEAR: begin
                // A done seen alongside our own start pulse is stale.
                if (clr_done && !clr_start_q) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (cap_hit) begin
                    state_d = S_DONE;
                end else if (seg_xfer) begin
                    state_d     = S_DRAW;
                    ld_start_d  = 1'b1;
                    seg_count_d = seg_count_q + CNT_W'(1);
                    last_d      = seg_last;
                    ld_x0_d     = seg_x0;
                    ld_y0_d     = seg_y0;
                    ld_x1_d     = seg_x1;
                    ld_y1_d     = seg_y1;
                end
            end
            S_DRAW: begin
                // The drawer's done is only trusted after it has seen ld_start.
                if (ld_done && !ld_start_q) begin
                    state_d = last_q ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        overrun_d    = overrun_q | (frame_tick & (state_q != S_IDLE));
        busy_d       = (state_d != S_IDLE);
        frame_done_d = (state_d == S_DONE);
    end

    // Framebuffer port mux; address and colour hold when no engine owns the port.
    always_comb begin
        fb_x_d     = fb_x_q;
        fb_y_d     = fb_y_q;
        fb_color_d = fb_color_q;
        fb_write_d = 1'b0;
        case (state_q)
            S_CLEAR: begin
                fb_x_d     = clr_x;
                fb_y_d     = clr_y;
                fb_color_d = 1'b0;
                fb_write_d = 1'b1;
            end
            S_DRAW: begin
                fb_x_d     = ld_x;
                fb_y_d     = ld_y;
                fb_color_d = 1'b1;
                fb_write_d = ld_pixel_valid;
            end
            default: begin
                fb_write_d = 1'b0;
            end
        endcase
    end

    assign clr_start  = clr_start_q;
    assign ld_start   = ld_start_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;
    assign seg_count  = seg_count_q;
    assign seg_ready  = seg_ready_d;
    assign ld_x0      = ld_x0_q;
    assign ld_y0      = ld_y0_q;
    assign ld_x1      = ld_x1_q;
    assign ld_y1      = ld_y1_q;
    assign fb_x       = fb_x_d;
    assign fb_y       = fb_y_d;
    assign fb_color   = fb_color_d;
    assign fb_write   = fb_write_d;

endmodule

// File: tb/tb_draw_scheduler.sv
// Self-checking bench for draw_scheduler: the bench plays clear engine,
// segment source and line drawer, and predicts each frame from a queue model.
module tb_draw_scheduler;

    localparam int COORD_W  = 11;
    localparam int MAX_SEGS = 16;
    localparam int CNT_W    = 5;

    typedef logic [COORD_W-1:0] crd_t;
    typedef struct {
        crd_t x0, y0, x1, y1;
        logic last;
        int   gap;
    } seg_t;
    typedef struct {
        crd_t x0, y0, x1, y1;
        int   nseg, pos, last_at, clr_len, ld_len;
        crd_t e_x0, e_y0, e_x1, e_y1;
        int   e_cnt, e_lds;
    } vec_t;

    logic clk, reset_n, frame_tick, clr_start, clr_done;
    crd_t clr_x, clr_y;
    logic seg_valid, seg_ready, seg_last;
    crd_t seg_x0, seg_y0, seg_x1, seg_y1;
    logic ld_start;
    crd_t ld_x0, ld_y0, ld_x1, ld_y1, ld_x, ld_y;
    logic ld_pixel_valid, ld_done;
    crd_t fb_x, fb_y;
    logic fb_color, fb_write, busy, frame_done, overrun;
    logic [CNT_W-1:0] seg_count;

    draw_scheduler #(.COORD_W(COORD_W), .MAX_SEGS(MAX_SEGS), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
        .clr_start(clr_start), .clr_done(clr_done), .clr_x(clr_x), .clr_y(clr_y),
        .seg_valid(seg_valid), .seg_ready(seg_ready),
        .seg_x0(seg_x0), .seg_y0(seg_y0), .seg_x1(seg_x1), .seg_y1(seg_y1),
        .seg_last(seg_last), .ld_start(ld_start),
        .ld_x0(ld_x0), .ld_y0(ld_y0), .ld_x1(ld_x1), .ld_y1(ld_y1),
        .ld_x(ld_x), .ld_y(ld_y), .ld_pixel_valid(ld_pixel_valid), .ld_done(ld_done),
        .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color), .fb_write(fb_write),
        .busy(busy), .frame_done(frame_done), .overrun(overrun), .seg_count(seg_count)
    );

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   ld_cnt = 0;
    bit   exp_ov;
    crd_t last_x, last_y;
    logic last_col;
    seg_t src_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent pulse counter for line-drawer starts.
    always @(negedge clk) begin
        if (ld_start === 1'b1) ld_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at t=%0t", nm, act, want, $time);
        end
    endfunction

    function automatic void timeout(string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: wait bound expired at t=%0t", nm, $time);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_idle();
        frame_tick     = 1'b0;
        clr_done       = 1'b0;
        clr_x          = crd_t'($urandom);
        clr_y          = crd_t'($urandom);
        seg_valid      = 1'b0;
        seg_x0         = crd_t'($urandom);
        seg_y0         = crd_t'($urandom);
        seg_x1         = crd_t'($urandom);
        seg_y1         = crd_t'($urandom);
        seg_last       = 1'($urandom);
        ld_x           = crd_t'($urandom);
        ld_y           = crd_t'($urandom);
        ld_pixel_valid = 1'($urandom);
        ld_done        = 1'b0;
    endtask

    task automatic offer(input seg_t s);
        seg_valid = 1'b1;
        seg_x0 = s.x0; seg_y0 = s.y0; seg_x1 = s.x1; seg_y1 = s.y1;
        seg_last = s.last;
    endtask

    task automatic chk_hold(string ph);
        chk({ph, "_fb_write"}, 32'(fb_write), 32'(0));
        chk({ph, "_fb_x"}, 32'(fb_x), 32'(last_x));
        chk({ph, "_fb_y"}, 32'(fb_y), 32'(last_y));
        chk({ph, "_fb_color"}, 32'(fb_color), 32'(last_col));
    endtask

    task automatic chk_reset(string ph);
        chk({ph, "_ctrl"}, 32'({clr_start, seg_ready, ld_start, frame_done,
                                busy, overrun, fb_write, fb_color}), 32'(0));
        chk({ph, "_fb_xy"}, 32'({fb_x, fb_y}), 32'(0));
        chk({ph, "_ld_p0"}, 32'({ld_x0, ld_y0}), 32'(0));
        chk({ph, "_ld_p1"}, 32'({ld_x1, ld_y1}), 32'(0));
        chk({ph, "_seg_count"}, 32'(seg_count), 32'(0));
    endtask

    task automatic do_reset();
        drive_idle();
        reset_n = 1'b0;
        #1;
        chk_reset("reset");
        repeat (2) @(posedge clk);
        #2;
        reset_n  = 1'b1;
        exp_ov   = 1'b0;
        last_x   = '0;
        last_y   = '0;
        last_col = 1'b0;
    endtask

    function automatic seg_t rand_seg(input logic last, input int gap);
        seg_t s;
        s.x0 = crd_t'($urandom); s.y0 = crd_t'($urandom);
        s.x1 = crd_t'($urandom); s.y1 = crd_t'($urandom);
        s.last = last;
        s.gap  = gap;
        return s;
    endfunction

    // Runs one frame from IDLE against src_q; the model is simply "take segments
    // in order until one is marked last or the per-frame budget is used up".
    task automatic run_frame(input int clr_len, input bit early_clr, input int ld_len_fix,
                             input bit early_ld, input bit tick_clear, input bit tick_done,
                             output int n_lds, output bit ok);
        seg_t exp_q[$];
        bit   capped;
        bit   xfer;
        int   ld0, waitc, ld_len;
        ok = 1'b1;
        n_lds = 0;
        exp_q = {};
        for (int i = 0; i < src_q.size() && exp_q.size() < MAX_SEGS; i++) begin
            exp_q.push_back(src_q[i]);
            if (src_q[i].last) break;
        end
        capped = (exp_q.size() == MAX_SEGS) && !exp_q[MAX_SEGS-1].last;
        ld0 = ld_cnt;

        drive_idle();
        frame_tick = 1'b1;
        #1;
        chk("pre_busy", 32'(busy), 32'(0));
        chk("pre_clr_start", 32'(clr_start), 32'(0));
        cyc();

        for (int c = 1; c <= clr_len; c++) begin
            drive_idle();
            clr_done   = (c == clr_len) || (c == 1 && early_clr);
            frame_tick = tick_clear && (c == 2);
            offer(src_q[0]);
            #1;
            chk("clr_start", 32'(clr_start), 32'(c == 1));
            chk("clr_fb_write", 32'(fb_write), 32'(1));
            chk("clr_fb_color", 32'(fb_color), 32'(0));
            chk("clr_fb_x", 32'(fb_x), 32'(clr_x));
            chk("clr_fb_y", 32'(fb_y), 32'(clr_y));
            chk("clr_seg_ready", 32'(seg_ready), 32'(0));
            chk("clr_busy", 32'(busy), 32'(1));
            if (c == 1) chk("clr_seg_count", 32'(seg_count), 32'(0));
            last_x = clr_x; last_y = clr_y; last_col = 1'b0;
            cyc();
        end
        if (tick_clear) exp_ov = 1'b1;

        for (int k = 0; k < exp_q.size(); k++) begin
            waitc = 0;
            xfer  = 1'b0;
            while (!xfer) begin
                if (waitc > 40) begin
                    timeout("fetch_wait");
                    ok = 1'b0;
                    return;
                end
                drive_idle();
                if (waitc >= src_q[0].gap) offer(src_q[0]);
                #1;
                chk("fetch_seg_ready", 32'(seg_ready), 32'(1));
                chk_hold("fetch");
                chk("fetch_ld_start", 32'(ld_start), 32'(0));
                chk("fetch_frame_done", 32'(frame_done), 32'(0));
                xfer = seg_valid && (seg_ready === 1'b1);
                cyc();
                waitc++;
            end
            void'(src_q.pop_front());
            ld_len = (ld_len_fix > 0) ? ld_len_fix : int'($urandom_range(1, 5));
            for (int d = 0; d <= ld_len; d++) begin
                drive_idle();
                ld_done = (d == ld_len) || (d == 0 && early_ld);
                #1;
                chk("draw_ld_start", 32'(ld_start), 32'(d == 0));
                chk("draw_ld_x0", 32'(ld_x0), 32'(exp_q[k].x0));
                chk("draw_ld_y0", 32'(ld_y0), 32'(exp_q[k].y0));
                chk("draw_ld_x1", 32'(ld_x1), 32'(exp_q[k].x1));
                chk("draw_ld_y1", 32'(ld_y1), 32'(exp_q[k].y1));
                chk("draw_fb_write", 32'(fb_write), 32'(ld_pixel_valid));
                chk("draw_fb_color", 32'(fb_color), 32'(1));
                chk("draw_fb_x", 32'(fb_x), 32'(ld_x));
                chk("draw_fb_y", 32'(fb_y), 32'(ld_y));
                chk("draw_seg_ready", 32'(seg_ready), 32'(0));
                chk("draw_seg_count", 32'(seg_count), 32'(k + 1));
                last_x = ld_x; last_y = ld_y; last_col = 1'b1;
                cyc();
            end
        end

        if (capped) begin
            drive_idle();
            if (src_q.size() > 0) offer(src_q[0]);
            #1;
            chk("cap_seg_ready", 32'(seg_ready), 32'(0));
            chk_hold("cap");
            chk("cap_frame_done", 32'(frame_done), 32'(0));
            chk("cap_seg_count", 32'(seg_count), 32'(MAX_SEGS));
            cyc();
        end

        drive_idle();
        frame_tick = tick_done;
        #1;
        chk("done_frame_done", 32'(frame_done), 32'(1));
        chk("done_busy", 32'(busy), 32'(1));
        chk("done_seg_ready", 32'(seg_ready), 32'(0));
        chk_hold("done");
        cyc();
        if (tick_done) exp_ov = 1'b1;

        drive_idle();
        if (src_q.size() > 0) offer(src_q[0]);
        #1;
        chk("idle_frame_done", 32'(frame_done), 32'(0));
        chk("idle_busy", 32'(busy), 32'(0));
        chk("idle_clr_start", 32'(clr_start), 32'(0));
        chk("idle_seg_ready", 32'(seg_ready), 32'(0));
        chk("idle_overrun", 32'(overrun), 32'(exp_ov));
        chk("idle_seg_count", 32'(seg_count), 32'(exp_q.size()));
        chk_hold("idle");
        cyc();
        n_lds = ld_cnt - ld0;
        chk("ld_pulses", 32'(n_lds), 32'(exp_q.size()));
    endtask

    initial begin
        vec_t tbl[5];
        int   nl;
        bit   ok;
        int   nseg, last_at;
        bit   tc, td;

        tbl[0] = '{11'd0,    11'd0,    11'd639, 11'd0,    1, 0,  0, 10, 5,
                   11'd0,    11'd0,    11'd639, 11'd0,    1,  1};
        tbl[1] = '{11'd2047, 11'd2047, 11'd0,   11'd0,    3, 2,  2,  2, 1,
                   11'd2047, 11'd2047, 11'd0,   11'd0,    3,  3};
        tbl[2] = '{11'd5,    11'd6,    11'd7,   11'd8,   16, 15, 15,  3, 2,
                   11'd5,    11'd6,    11'd7,   11'd8,   16, 16};
        tbl[3] = '{11'd100,  11'd200,  11'd300, 11'd400, 20, 15, -1,  4, 3,
                   11'd100,  11'd200,  11'd300, 11'd400, 16, 16};
        tbl[4] = '{11'd639,  11'd479,  11'd0,   11'd479,  5, 1,  1,  2, 1,
                   11'd639,  11'd479,  11'd0,   11'd479,  2,  2};

        reset_n = 1'b1;
        drive_idle();
        #1;
        do_reset();

        // Table of single- and multi-segment frames with fixed expectations.
        for (int t = 0; t < 5; t++) begin
            src_q = {};
            for (int i = 0; i < tbl[t].nseg; i++)
                src_q.push_back(rand_seg(i == tbl[t].last_at, int'($urandom_range(0, 2))));
            src_q[tbl[t].pos].x0 = tbl[t].x0;
            src_q[tbl[t].pos].y0 = tbl[t].y0;
            src_q[tbl[t].pos].x1 = tbl[t].x1;
            src_q[tbl[t].pos].y1 = tbl[t].y1;
            run_frame(tbl[t].clr_len, 1'b0, tbl[t].ld_len, 1'b0, 1'b0, 1'b0, nl, ok);
            if (!ok) do_reset();
            chk("tbl_ld_x0", 32'(ld_x0), 32'(tbl[t].e_x0));
            chk("tbl_ld_y0", 32'(ld_y0), 32'(tbl[t].e_y0));
            chk("tbl_ld_x1", 32'(ld_x1), 32'(tbl[t].e_x1));
            chk("tbl_ld_y1", 32'(ld_y1), 32'(tbl[t].e_y1));
            chk("tbl_seg_count", 32'(seg_count), 32'(tbl[t].e_cnt));
            chk("tbl_ld_starts", 32'(nl), 32'(tbl[t].e_lds));
        end

        // Backpressure: source stalls 4 cycles before the third segment.
        src_q = {};
        src_q.push_back(rand_seg(1'b0, 0));
        src_q.push_back(rand_seg(1'b0, 0));
        src_q.push_back(rand_seg(1'b1, 4));
        run_frame(3, 1'b0, 3, 1'b0, 1'b0, 1'b0, nl, ok);
        if (!ok) do_reset();
        chk("bp_ld_starts", 32'(nl), 32'(3));
        chk("bp_seg_count", 32'(seg_count), 32'(3));

        // Overrun: ticks during CLEAR and during DONE are dropped; flag is sticky.
        src_q = {};
        src_q.push_back(rand_seg(1'b0, 1));
        src_q.push_back(rand_seg(1'b1, 0));
        run_frame(4, 1'b0, 0, 1'b0, 1'b1, 1'b1, nl, ok);
        if (!ok) do_reset();
        src_q = {};
        src_q.push_back(rand_seg(1'b1, 0));
        run_frame(2, 1'b0, 2, 1'b0, 1'b0, 1'b0, nl, ok);
        if (!ok) do_reset();
        chk("ovr_sticky", 32'(overrun), 32'(exp_ov));

        // Early done: clr_done with clr_start and ld_done with ld_start are stale.
        src_q = {};
        src_q.push_back(rand_seg(1'b0, 0));
        src_q.push_back(rand_seg(1'b1, 0));
        run_frame(2, 1'b1, 3, 1'b1, 1'b0, 1'b0, nl, ok);
        if (!ok) do_reset();

        // Reset asserted in the middle of DRAW.
        drive_idle(); frame_tick = 1'b1; #1; cyc();
        drive_idle(); #1; chk("rs_clr_start", 32'(clr_start), 32'(1)); cyc();
        drive_idle(); clr_done = 1'b1; #1; cyc();
        drive_idle(); offer(rand_seg(1'b1, 0)); #1;
        chk("rs_seg_ready", 32'(seg_ready), 32'(1)); cyc();
        drive_idle(); #1; chk("rs_ld_start", 32'(ld_start), 32'(1)); cyc();
        drive_idle(); ld_pixel_valid = 1'b1; #1;
        chk("rs_fb_write", 32'(fb_write), 32'(1));
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive_idle();
            clr_done = 1'b1; ld_done = 1'b1; offer(rand_seg(1'b1, 0));
            #1;
            chk("post_rst_ctrl", 32'({clr_start, ld_start, busy, fb_write, seg_ready, overrun}),
                32'(0));
            cyc();
        end

        // Randomized frames against the queue model.
        for (int f = 0; f < 25; f++) begin
            src_q   = {};
            nseg    = int'($urandom_range(1, 20));
            last_at = int'($urandom_range(0, nseg - 1));
            if (nseg >= MAX_SEGS && $urandom_range(0, 2) == 0) last_at = -1;
            for (int i = 0; i < nseg; i++)
                src_q.push_back(rand_seg(i == last_at, int'($urandom_range(0, 3))));
            tc = ($urandom_range(0, 7) == 0);
            td = ($urandom_range(0, 7) == 0);
            run_frame(int'($urandom_range(2, 6)), 1'($urandom), 0, 1'($urandom), tc, td, nl, ok);
            if (!ok) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
